branch_resolution_ctrl: RTL and testbench
=========================================

Name: branch_resolution_ctrl

Overview:
- Sequences the branch predictor across the 5-stage pipeline: records every IF-stage prediction in an in-order queue and retires the head record when that instruction resolves in EX.
- On a wrong next-PC it squashes IF/ID and ID/EX, redirects the PC, and emits a one-cycle registered update to the Gshare predictor (PHT counter, BHSR, BTB/tag write).
- Keeps branch and mispredict statistics.

Parameters:
- DEPTH, 4, prediction queue entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_fire  in  1  IF issues an instruction this cycle; push a record
- fetch_pc  in  32  PC of the fetched instruction
- pred_next_pc  in  32  predictor's next_pc for fetch_pc
- pred_pht_index  in  5  PHT index used for the prediction
- ex_valid  in  1  instruction in EX resolves this cycle; pop the head record
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_is_jal  in  1  EX instruction is JAL
- ex_is_jalr  in  1  EX instruction is JALR
- ex_taken  in  1  branch outcome; ignored for non-branches
- ex_target  in  32  computed target
- stall_fetch  out  1  queue full; IF must hold
- flush_if_id  out  1  squash the IF/ID register
- flush_id_ex  out  1  squash the ID/EX register
- redirect_valid  out  1  load redirect_pc into the PC
- redirect_pc  out  32  correct next PC
- upd_is_branch  out  1  predictor update for a conditional branch
- upd_is_jal  out  1  predictor update for JAL
- upd_is_jalr  out  1  predictor update for JALR
- upd_taken  out  1  actual outcome; 1 for JAL/JALR
- upd_correct  out  1  prediction was correct
- upd_pht_index  out  5  PHT index from the record
- upd_pc  out  32  PC of the resolved instruction
- upd_target  out  32  actual target
- q_count  out  PTR_W+1  current occupancy
- branch_count  out  32  resolved control instructions, saturating
- mispredict_count  out  32  mispredictions, saturating
- proto_err  out  1  sticky protocol error

Behaviour:
- Reset: queue empty, state RUN, all outputs 0, counters 0, proto_err 0. A reset mid-flush aborts the flush.
- Queue: circular buffer of {pc, pred_next_pc, pht_index} with rd/wr pointers that wrap modulo DEPTH. stall_fetch = (q_count == DEPTH), combinational.
- Push: fetch_fire && !full && state==RUN.
- fetch_fire while full: ignored and sets proto_err.
- Pop: ex_valid && state==RUN && q_count!=0.
- ex_valid while empty: no pop, no update, sets proto_err.
- Push and pop in the same cycle: q_count unchanged. Legal when full, because the pop frees the slot; stall_fetch is still evaluated on the pre-pop count.
- Resolution, combinational on the head record:
  - ctrl = is_branch|is_jal|is_jalr.
  - actual_next = ((is_branch&&taken)||is_jal||is_jalr) ? ex_target : head.pc+4 (mod 2^32).
  - correct = (actual_next == head.pred_next_pc).
- Update outputs (upd_*): registered. Exactly one cycle, in the cycle after a pop with ctrl=1. Otherwise all upd_* are 0. upd_taken = is_branch ? ex_taken : 1.
- FSM: RUN and FLUSH.
- RUN -> FLUSH on a pop with correct=0, including non-control instructions predicted as taken (stale BTB).
  - Same edge: queue cleared (q_count=0) and any simultaneous push discarded, because the flush wins.
  - redirect_pc latched to actual_next.
- FLUSH lasts exactly one cycle:
  - flush_if_id = flush_id_ex = redirect_valid = 1.
  - fetch_fire and ex_valid are ignored with no proto_err.
  - Next state RUN.
- In RUN, flush and redirect outputs are 0.
- Counters:
  - branch_count += 1 per pop with ctrl=1.
  - mispredict_count += 1 per pop with correct=0.
  - Both saturate at 0xFFFFFFFF.
- Latency: resolve in cycle N; redirect, flush and upd_* in N+1; first correct-path push accepted in N+2.

Test Plan:
- Reset, then 4 fetches (pc 0x00,0x04,0x08,0x0C, pred = pc+4) with no ex_valid -> q_count=4, stall_fetch=1; a 5th fetch_fire sets proto_err=1, q_count stays 4.
- Queue full, push+pop same cycle on a correct non-control head -> q_count=4, no upd_*, no flush, proto_err unchanged.
- Head pc 0x10, pred 0x14, branch taken, target 0x40 -> next cycle: redirect_pc=0x40, redirect_valid=flush_if_id=flush_id_ex=1 for 1 cycle, upd_is_branch=1, upd_taken=1, upd_correct=0, upd_pc=0x10, upd_pht_index=recorded value; q_count=0; mispredict_count=1.
- JAL at 0x20 with pred 0x80, ex_target 0x80 -> no flush, upd_is_jal=1, upd_correct=1, upd_taken=1; branch_count increments, mispredict_count unchanged.
- Non-control at 0x30 predicted 0x100 -> flush, redirect_pc=0x34, no upd_* pulse; fetch_fire during FLUSH not enqueued.
- Mispredict resolves while fetch_fire=1, then reset asserted during FLUSH -> pushed record discarded; after reset all outputs 0 and q_count=0.

Source files
------------

// File: rtl/branch_resolution_ctrl.sv
// Tracks in-flight branch predictions from IF to EX, resolves them against the
// actual outcome, and drives squash/redirect plus a one-cycle predictor update.
module branch_resolution_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_fire,
  input  logic [31:0]      fetch_pc,
  input  logic [31:0]      pred_next_pc,
  input  logic [4:0]       pred_pht_index,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             stall_fetch,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             upd_is_branch,
  output logic             upd_is_jal,
  output logic             upd_is_jalr,
  output logic             upd_taken,
  output logic             upd_correct,
  output logic [4:0]       upd_pht_index,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic [PTR_W:0]   q_count,
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count,
  output logic             proto_err
);

  typedef enum logic [0:0] {RUN, FLUSH} state_t;

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  state_t state, next_state;

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      pred_mem [DEPTH];
  logic [4:0]       idx_mem  [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  logic        full, in_run, push, pop;
  logic        ctrl, redirects, correct, mispredict;
  logic [31:0] head_pc, head_pred, actual_next;

  assign full        = (q_count == FULL_CNT);
  assign stall_fetch = full;
  assign in_run      = (state == RUN);
  assign pop         = ex_valid && in_run && (q_count != '0);
  // A pop in the same cycle frees the slot, so a full queue may still accept a push.
  assign push        = fetch_fire && in_run && (!full || pop);

  assign head_pc     = pc_mem[rd_ptr];
  assign head_pred   = pred_mem[rd_ptr];
  assign ctrl        = ex_is_branch | ex_is_jal | ex_is_jalr;
  assign redirects   = (ex_is_branch && ex_taken) || ex_is_jal || ex_is_jalr;
  assign actual_next = redirects ? ex_target : head_pc + 32'd4;
  assign correct     = (actual_next == head_pred);
  assign mispredict  = pop && !correct;

  assign flush_if_id    = (state == FLUSH);
  assign flush_id_ex    = (state == FLUSH);
  assign redirect_valid = (state == FLUSH);

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (mispredict) next_state = FLUSH;
      FLUSH:   next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !mispredict) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      pred_mem[wr_ptr] <= pred_next_pc;
      idx_mem[wr_ptr]  <= pred_pht_index;
    end
  end

  // A mispredict empties the queue and drops any same-cycle push.
  always_ff @(posedge clk) begin
    if (reset || mispredict) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      q_count <= q_count + 1'b1;
      else if (pop && !push) q_count <= q_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_is_branch <= 1'b0;
      upd_is_jal    <= 1'b0;
      upd_is_jalr   <= 1'b0;
      upd_taken     <= 1'b0;
      upd_correct   <= 1'b0;
      upd_pht_index <= '0;
      upd_pc        <= '0;
      upd_target    <= '0;
      redirect_pc   <= '0;
    end else begin
      upd_is_branch <= pop && ex_is_branch;
      upd_is_jal    <= pop && ex_is_jal;
      upd_is_jalr   <= pop && ex_is_jalr;
      upd_taken     <= pop && ctrl && (ex_is_branch ? ex_taken : 1'b1);
      upd_correct   <= pop && ctrl && correct;
      upd_pht_index <= (pop && ctrl) ? idx_mem[rd_ptr] : 5'd0;
      upd_pc        <= (pop && ctrl) ? head_pc : 32'd0;
      upd_target    <= (pop && ctrl) ? ex_target : 32'd0;
      redirect_pc   <= mispredict ? actual_next : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
      proto_err        <= 1'b0;
    end else begin
      if (pop && ctrl && branch_count != 32'hFFFF_FFFF)
        branch_count <= branch_count + 32'd1;
      if (mispredict && mispredict_count != 32'hFFFF_FFFF)
        mispredict_count <= mispredict_count + 32'd1;
      if (in_run && ((fetch_fire && full && !pop) || (ex_valid && q_count == '0)))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolution_ctrl.sv
// Randomized bench for branch_resolution_ctrl, checked every cycle against a
// queue-based reference model of the resolution rules.
module tb_branch_resolution_ctrl;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             fetch_fire;
  logic [31:0]      fetch_pc, pred_next_pc;
  logic [4:0]       pred_pht_index;
  logic             ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_taken;
  logic [31:0]      ex_target;
  logic             stall_fetch, flush_if_id, flush_id_ex, redirect_valid;
  logic [31:0]      redirect_pc;
  logic             upd_is_branch, upd_is_jal, upd_is_jalr, upd_taken, upd_correct;
  logic [4:0]       upd_pht_index;
  logic [31:0]      upd_pc, upd_target;
  logic [PTR_W:0]   q_count;
  logic [31:0]      branch_count, mispredict_count;
  logic             proto_err;

  branch_resolution_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .fetch_fire(fetch_fire), .fetch_pc(fetch_pc), .pred_next_pc(pred_next_pc),
    .pred_pht_index(pred_pht_index),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_taken(ex_taken), .ex_target(ex_target),
    .stall_fetch(stall_fetch), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_is_branch(upd_is_branch), .upd_is_jal(upd_is_jal), .upd_is_jalr(upd_is_jalr),
    .upd_taken(upd_taken), .upd_correct(upd_correct), .upd_pht_index(upd_pht_index),
    .upd_pc(upd_pc), .upd_target(upd_target), .q_count(q_count),
    .branch_count(branch_count), .mispredict_count(mispredict_count),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
    logic [4:0]  idx;
  } rec_t;

  rec_t        mq[$];
  bit          m_flush;
  logic [31:0] e_redirect, e_bc, e_mc, e_upd_pc, e_upd_tgt;
  logic [4:0]  e_upd_idx;
  bit          e_br, e_jal, e_jalr, e_tk, e_ok, e_perr;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: one step of the resolution rules using the inputs now driven.
  task automatic modelStep();
    bit          full, dopop, dopush, iscf, jumps, ok, mis;
    logic [31:0] act;
    rec_t        h;
    e_br = 0; e_jal = 0; e_jalr = 0; e_tk = 0; e_ok = 0;
    e_upd_idx = 0; e_upd_pc = 0; e_upd_tgt = 0; e_redirect = 0;
    if (reset) begin
      mq.delete(); m_flush = 0; e_bc = 0; e_mc = 0; e_perr = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else begin
      full   = (mq.size() == DEPTH);
      dopop  = ex_valid && mq.size() != 0;
      dopush = fetch_fire && (!full || dopop);
      if (ex_valid && mq.size() == 0) e_perr = 1;
      if (fetch_fire && full && !dopop) e_perr = 1;
      mis = 0;
      act = 0;
      if (dopop) begin
        h     = mq.pop_front();
        iscf  = ex_is_branch || ex_is_jal || ex_is_jalr;
        jumps = (ex_is_branch && ex_taken) || ex_is_jal || ex_is_jalr;
        act   = jumps ? ex_target : h.pc + 32'd4;
        ok    = (act == h.pred);
        if (iscf) begin
          e_br = ex_is_branch; e_jal = ex_is_jal; e_jalr = ex_is_jalr;
          e_tk = ex_is_branch ? ex_taken : 1'b1;
          e_ok = ok; e_upd_idx = h.idx; e_upd_pc = h.pc; e_upd_tgt = ex_target;
          if (e_bc != 32'hFFFF_FFFF) e_bc++;
        end
        if (!ok) begin
          mis = 1;
          if (e_mc != 32'hFFFF_FFFF) e_mc++;
        end
      end
      if (mis) begin
        mq.delete();
        m_flush = 1;
        e_redirect = act;
      end else if (dopush) begin
        mq.push_back('{pc: fetch_pc, pred: pred_next_pc, idx: pred_pht_index});
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit ff, input logic [31:0] fpc,
                               input logic [31:0] fpred, input logic [4:0] fidx,
                               input bit exv, input bit br, input bit jal, input bit jalr,
                               input bit tk, input logic [31:0] tgt);
    reset = r; fetch_fire = ff; fetch_pc = fpc; pred_next_pc = fpred;
    pred_pht_index = fidx; ex_valid = exv; ex_is_branch = br; ex_is_jal = jal;
    ex_is_jalr = jalr; ex_taken = tk; ex_target = tgt;
    checkOutput("stall_fetch", 32'(stall_fetch), 32'(mq.size() == DEPTH && !m_flush));
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("q_count", 32'(q_count), 32'(mq.size()));
    checkOutput("flush_if_id", 32'(flush_if_id), 32'(m_flush));
    checkOutput("flush_id_ex", 32'(flush_id_ex), 32'(m_flush));
    checkOutput("redirect_valid", 32'(redirect_valid), 32'(m_flush));
    checkOutput("redirect_pc", redirect_pc, e_redirect);
    checkOutput("upd_is_branch", 32'(upd_is_branch), 32'(e_br));
    checkOutput("upd_is_jal", 32'(upd_is_jal), 32'(e_jal));
    checkOutput("upd_is_jalr", 32'(upd_is_jalr), 32'(e_jalr));
    checkOutput("upd_taken", 32'(upd_taken), 32'(e_tk));
    checkOutput("upd_correct", 32'(upd_correct), 32'(e_ok));
    checkOutput("upd_pht_index", 32'(upd_pht_index), 32'(e_upd_idx));
    checkOutput("upd_pc", upd_pc, e_upd_pc);
    checkOutput("upd_target", upd_target, e_upd_tgt);
    checkOutput("branch_count", branch_count, e_bc);
    checkOutput("mispredict_count", mispredict_count, e_mc);
    checkOutput("proto_err", 32'(proto_err), 32'(e_perr));
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fetchOnly(input logic [31:0] pc, input logic [31:0] pred, input logic [4:0] idx);
    applyStimulus(0, 1, pc, pred, idx, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] rpc, rpred, rtgt;
    int kind;
    m_flush = 0; e_bc = 0; e_mc = 0; e_perr = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fill the queue, then overflow it.
    for (int i = 0; i < 4; i++) fetchOnly(32'(i * 4), 32'(i * 4 + 4), 5'(i + 1));
    fetchOnly(32'h10, 32'h14, 5'd9);

    // Full queue: pop correct non-control head while pushing pc 0x10.
    applyStimulus(0, 1, 32'h10, 32'h14, 5'd5, 1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0);

    // Head 0x10 predicted fall-through, branch taken to 0x40: mispredict.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 32'h40);
    idleCycle();

    // Correctly predicted JAL.
    fetchOnly(32'h20, 32'h80, 5'd7);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 32'h80);

    // Non-control predicted taken (stale BTB); fetch during FLUSH is dropped.
    fetchOnly(32'h30, 32'h100, 5'd3);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, 32'h34, 32'h38, 5'd2, 1, 0, 0, 0, 0, 32'h0);
    idleCycle();

    // Mispredict with simultaneous fetch, then reset during FLUSH.
    fetchOnly(32'h40, 32'h44, 5'd4);
    applyStimulus(0, 1, 32'h44, 32'h48, 5'd6, 1, 1, 0, 0, 1, 32'h80);
    applyStimulus(1, 1, 32'h80, 32'h84, 5'd1, 0, 0, 0, 0, 0, 32'h0);
    idleCycle();

    for (int n = 0; n < 500; n++) begin
      rpc   = 32'($urandom_range(0, 63)) << 2;
      rpred = ($urandom_range(0, 2) != 0) ? rpc + 32'd4 : (32'($urandom_range(0, 63)) << 2);
      kind  = $urandom_range(0, 3);
      rtgt  = 32'($urandom_range(0, 63)) << 2;
      if (mq.size() != 0 && $urandom_range(0, 1) == 1) rtgt = mq[0].pred;
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, rpc, rpred,
                    5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0,
                    kind == 1, kind == 2, kind == 3, $urandom_range(0, 1) == 1, rtgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
